jlsemi_util_clkgate_ctrl: RTL and testbench

//  Controller for NUM_DOM clock-gated domains. Each domain is gated by its own jlsemi_util_clkgate.

---
 rtl/jlsemi_util_clkgate_ctrl_pkg.sv | 23 ++
 rtl/jlsemi_util_clkgate_dom_fsm.sv | 102 ++++++++++
 rtl/jlsemi_util_clkgate_ctrl.sv | 81 ++++++++
 tb/tb_jlsemi_util_clkgate_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jlsemi_util_clkgate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate controller and its per-domain FSMs.
package jlsemi_util_clkgate_ctrl_pkg;

  // Per-domain state encoding
  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_WAIT = 3'd1,
    ST_WAKE = 3'd2,
    ST_ON   = 3'd3,
    ST_IDLE = 3'd4
  } dom_state_e;

  // Bits needed to hold the values 0..max_val (never less than one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items (never less than one bit)
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jlsemi_util_clkgate_dom_fsm.sv
// Per-domain gating FSM: wake window timer, idle timer, registered enable/ack.
//
//  state | meaning
//  OFF   | clock gated, no activity
//  WAIT  | activity seen, waiting for the shared wake slot
//  WAKE  | clock enabled, settling for WAKE_CYC cycles (always completes)
//  ON    | clock running, ack given
//  IDLE  | clock running, counting idle cycles toward gate-off
module jlsemi_util_clkgate_dom_fsm
  import jlsemi_util_clkgate_ctrl_pkg::*;
#(
  parameter int WAKE_CYC = 4,
  parameter int IDLE_W   = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              act_i,
  input  logic              gnt_i,
  input  logic [IDLE_W-1:0] thr_i,
  output logic              en_o,
  output logic              ack_o,
  output logic              is_wait_o,
  output logic              is_wake_o
);

  localparam int                WCNT_W    = cnt_width(WAKE_CYC);
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

  dom_state_e        state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [IDLE_W-1:0] icnt_q;
  logic              en_q;
  logic              ack_q;
  logic              idle_expired;

  // Threshold is compared live, so a lowered threshold (cnt+1 >= thr) expires at once
  assign idle_expired = (thr_i != '0) &&
                        (({1'b0, icnt_q} + {{IDLE_W{1'b0}}, 1'b1}) >= {1'b0, thr_i});

  // State machine with registered enable/ack and both timers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_OFF;
      wcnt_q  <= '0;
      icnt_q  <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (act_i) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gnt_i) begin
            state_q <= ST_WAKE;
            wcnt_q  <= '0;
            en_q    <= 1'b1;
          end else if (!act_i) begin
            state_q <= ST_OFF;
          end
        end
        ST_WAKE: begin
          if (wcnt_q == WAKE_LAST) begin
            state_q <= ST_ON;
            ack_q   <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        ST_ON: begin
          if (!act_i && (thr_i != '0)) begin
            state_q <= ST_IDLE;
            icnt_q  <= '0;
          end
        end
        ST_IDLE: begin
          if (act_i) begin
            state_q <= ST_ON;
          end else if (idle_expired) begin
            state_q <= ST_OFF;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
          end else if (icnt_q != IDLE_MAX) begin
            icnt_q <= icnt_q + IDLE_W'(1);
          end
        end
        default: begin
          state_q <= ST_OFF;
          en_q    <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign en_o      = en_q;
  assign ack_o     = ack_q;
  assign is_wait_o = (state_q == ST_WAIT);
  assign is_wake_o = (state_q == ST_WAKE);

endmodule

// File: rtl/jlsemi_util_clkgate_ctrl.sv
// Clock-gate controller: per-domain FSMs plus a round-robin single-slot wake scheduler.
module jlsemi_util_clkgate_ctrl
  import jlsemi_util_clkgate_ctrl_pkg::*;
#(
  parameter int NUM_DOM  = 4,
  parameter int WAKE_CYC = 4,
  parameter int IDLE_W   = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [IDLE_W-1:0]  cfg_idle_thr_i,
  input  logic [NUM_DOM-1:0] cfg_force_on_i,
  input  logic [NUM_DOM-1:0] req_i,
  input  logic [NUM_DOM-1:0] busy_i,
  output logic [NUM_DOM-1:0] clk_en_o,
  output logic [NUM_DOM-1:0] ack_o,
  output logic               wake_busy_o
);

  localparam int PTR_W = idx_width(NUM_DOM);

  logic [NUM_DOM-1:0] act;
  logic [NUM_DOM-1:0] gnt;
  logic [NUM_DOM-1:0] is_wait;
  logic [NUM_DOM-1:0] is_wake;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W-1:0]   idx_l;
  logic               found;
  int                 idx;

  assign act         = req_i | busy_i | cfg_force_on_i;
  assign wake_busy_o = |is_wake;

  // Grant the first waiting domain at or after ptr, only while the wake slot is free
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_l = '0;
    if (!(|is_wake)) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        idx   = (int'(ptr_q) + i) % NUM_DOM;
        idx_l = PTR_W'(idx);
        if (!found && is_wait[idx_l]) begin
          found      = 1'b1;
          gnt[idx_l] = 1'b1;
          ptr_d      = PTR_W'((idx + 1) % NUM_DOM);
        end
      end
    end
  end

  // Round-robin pointer advances past each grantee
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else if (|gnt) begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
    jlsemi_util_clkgate_dom_fsm #(
      .WAKE_CYC (WAKE_CYC),
      .IDLE_W   (IDLE_W)
    ) u_fsm (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .act_i     (act[d]),
      .gnt_i     (gnt[d]),
      .thr_i     (cfg_idle_thr_i),
      .en_o      (clk_en_o[d]),
      .ack_o     (ack_o[d]),
      .is_wait_o (is_wait[d]),
      .is_wake_o (is_wake[d])
    );
  end

endmodule

// File: tb/tb_jlsemi_util_clkgate_ctrl.sv
// Directed bench for the clock-gate controller (NUM_DOM=4, WAKE_CYC=4, IDLE_W=8).
module tb_jlsemi_util_clkgate_ctrl;

  logic       clk_i;
  logic       rstn_i;
  logic [7:0] cfg_idle_thr_i;
  logic [3:0] cfg_force_on_i;
  logic [3:0] req_i;
  logic [3:0] busy_i;
  logic [3:0] clk_en_o;
  logic [3:0] ack_o;
  logic       wake_busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  int two_wake_cnt = 0;
  int en2_cnt      = 0;
  int en0_low_cnt  = 0;

  jlsemi_util_clkgate_ctrl #(
    .NUM_DOM  (4),
    .WAKE_CYC (4),
    .IDLE_W   (8)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_idle_thr_i (cfg_idle_thr_i),
    .cfg_force_on_i (cfg_force_on_i),
    .req_i          (req_i),
    .busy_i         (busy_i),
    .clk_en_o       (clk_en_o),
    .ack_o          (ack_o),
    .wake_busy_o    (wake_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Cycle monitors sampled away from the active edge
  always @(negedge clk_i) begin
    if ($countones(clk_en_o & ~ack_o) > 1) two_wake_cnt++;
    if (clk_en_o[2]) en2_cnt++;
    if (!clk_en_o[0]) en0_low_cnt++;
  end

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         cyc;
    logic [3:0] en;
    logic [3:0] ack;
    logic       wb;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] en, input logic [3:0] ack,
                         input logic wb);
    chk({nm, " en"},  32'(clk_en_o),    32'(en));
    chk({nm, " ack"}, 32'(ack_o),       32'(ack));
    chk({nm, " wb"},  32'(wake_busy_o), 32'(wb));
  endtask

  initial begin
    int snap;

    // single wake on d1 with thr=3: en@2, ack@6, last req @10 -> off @15
    vecs[0]  = '{1'b1, 4'h2, 1, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'h2, 1, 4'h2, 4'h0, 1'b1};
    vecs[2]  = '{1'b0, 4'h2, 3, 4'h2, 4'h0, 1'b1};
    vecs[3]  = '{1'b0, 4'h2, 1, 4'h2, 4'h2, 1'b0};
    vecs[4]  = '{1'b0, 4'h2, 4, 4'h2, 4'h2, 1'b0};
    vecs[5]  = '{1'b0, 4'h2, 1, 4'h2, 4'h2, 1'b0};
    vecs[6]  = '{1'b0, 4'h0, 1, 4'h2, 4'h2, 1'b0};
    vecs[7]  = '{1'b0, 4'h0, 2, 4'h2, 4'h2, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 1, 4'h0, 4'h0, 1'b0};
    // contention from ptr=0: acks at 6, 11, 16, 21
    vecs[9]  = '{1'b1, 4'hF, 1, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 1, 4'h1, 4'h0, 1'b1};
    vecs[11] = '{1'b0, 4'hF, 4, 4'h1, 4'h1, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 1, 4'h3, 4'h1, 1'b1};
    vecs[13] = '{1'b0, 4'hF, 4, 4'h3, 4'h3, 1'b0};
    vecs[14] = '{1'b0, 4'hF, 1, 4'h7, 4'h3, 1'b1};
    vecs[15] = '{1'b0, 4'hF, 4, 4'h7, 4'h7, 1'b0};
    vecs[16] = '{1'b0, 4'hF, 1, 4'hF, 4'h7, 1'b1};
    vecs[17] = '{1'b0, 4'hF, 4, 4'hF, 4'hF, 1'b0};

    // reset with all requests high
    rstn_i         = 1'b0;
    cfg_idle_thr_i = 8'd3;
    cfg_force_on_i = 4'h0;
    req_i          = 4'hF;
    busy_i         = 4'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_out("reset_held", 4'h0, 4'h0, 1'b0);
    req_i  = 4'h0;
    rstn_i = 1'b1;
    repeat (3) step();
    chk_out("reset_released", 4'h0, 4'h0, 1'b0);

    // table-driven single wake and contention
    for (int k = 0; k < NV; k++) begin
      if (vecs[k].rst) do_reset();
      req_i = vecs[k].req;
      repeat (vecs[k].cyc) step();
      chk_out($sformatf("vec%0d", k), vecs[k].en, vecs[k].ack, vecs[k].wb);
    end
    chk("single_wake_slot", 32'(two_wake_cnt), 32'd0);

    // withdraw: d2 pulses one cycle while d0 holds the slot
    req_i = 4'h0;
    do_reset();
    req_i = 4'h1;
    repeat (3) step();
    chk_out("withdraw_c3", 4'h1, 4'h0, 1'b1);
    snap  = en2_cnt;
    req_i = 4'h5;
    step();
    req_i = 4'h1;
    repeat (9) step();
    chk_out("withdraw_c13", 4'h1, 4'h1, 1'b0);
    chk("withdraw_en2", 32'(en2_cnt - snap), 32'd0);

    // re-activation in the exact timeout cycle
    req_i = 4'h0;
    do_reset();
    busy_i = 4'h1;
    repeat (8) step();
    chk_out("race_on", 4'h1, 4'h1, 1'b0);
    snap   = en0_low_cnt;
    busy_i = 4'h0;
    repeat (3) step();
    chk_out("race_idle", 4'h1, 4'h1, 1'b0);
    busy_i = 4'h1;
    step();
    chk_out("race_kept", 4'h1, 4'h1, 1'b0);
    repeat (5) step();
    chk("race_no_drop", 32'(en0_low_cnt - snap), 32'd0);

    // thr=0 disables auto-off
    cfg_idle_thr_i = 8'd0;
    busy_i         = 4'h0;
    repeat (300) step();
    chk_out("thr0_on", 4'h1, 4'h1, 1'b0);
    chk("thr0_no_drop", 32'(en0_low_cnt - snap), 32'd0);

    // live threshold lowered below cnt+1 gates off next cycle
    cfg_idle_thr_i = 8'd10;
    repeat (6) step();
    chk_out("thr_live_before", 4'h1, 4'h1, 1'b0);
    cfg_idle_thr_i = 8'd2;
    step();
    chk_out("thr_live_after", 4'h0, 4'h0, 1'b0);

    // force-on holds d3 with req/busy low
    cfg_idle_thr_i = 8'd3;
    do_reset();
    cfg_force_on_i = 4'h8;
    repeat (2) step();
    chk_out("force_wake", 4'h8, 4'h0, 1'b1);
    repeat (4) step();
    chk_out("force_ack", 4'h8, 4'h8, 1'b0);
    repeat (20) step();
    chk_out("force_hold", 4'h8, 4'h8, 1'b0);

    // reset asserted mid-WAKE clears outputs without waiting for an edge
    do_reset();
    repeat (2) step();
    chk_out("rewake_pre", 4'h8, 4'h0, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk_out("async_reset", 4'h0, 4'h0, 1'b0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    repeat (2) step();
    chk_out("rewake_wake", 4'h8, 4'h0, 1'b1);
    repeat (4) step();
    chk_out("rewake_ack", 4'h8, 4'h8, 1'b0);

    chk("single_wake_slot_all", 32'(two_wake_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
